hazard_stall_ctrl: RTL and testbench
====================================

# hazard_stall_ctrl

Pipeline hazard and stall controller sequencing the IF/ID and ID/EX stage registers of the 5-stage MIPS pipeline. It detects load-use hazards between decode and execute and squashes wrong-path instructions after a taken branch. It also freezes the front end while the memory stage reports not-ready. It drives PC/IF-ID write enables, the IF/ID flush, and a bubble select that zeroes ID/EX control bits (MemRead, MemWrite, RegWrite, Branch, PCSrc), since ID/EX has no enable.

## Interface
Parameters:
- BRANCH_PENALTY, 2: cycles of flush after a taken branch (≥1).
- WAIT_LIMIT, 255: max consecutive ext_stall cycles before the timeout flag; 8-bit range.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- id_rs, id_rt  in  5 each  source register fields of the instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt as a source (R-type, beq, sw).
- ex_mem_read  in  1  ID/EX MemRead (load in EX).
- ex_rt  in  5  ID/EX destination rt of that load.
- ex_branch_taken  in  1  branch resolved taken this cycle (PCSrc).
- ext_stall  in  1  memory stage not ready.
- pc_write  out  1  PC load enable.
- ifid_write  out  1  IF/ID load enable.
- ifid_flush  out  1  IF/ID loads a NOP.
- idex_bubble  out  1  ID/EX loads zeroed control bits.
- stall_cycles  out  16  saturating count of cycles with pc_write=0.
- stall_timeout  out  1  sticky: ext_stall exceeded WAIT_LIMIT.

## Operation
- States: RUN, FLUSH, WAIT. Outputs are Mealy: decoded from state plus current inputs.
- Load-use hazard: lu = ex_mem_read & ex_rt≠0 & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).
- Priority in RUN: ex_branch_taken > ext_stall > lu.
- RUN, branch taken: pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1. If BRANCH_PENALTY>1, go to FLUSH with cnt=BRANCH_PENALTY-1; otherwise stay in RUN.
- RUN, ext_stall: pc_write=0, ifid_write=0, idex_bubble=1. Go to WAIT with wcnt=1.
- RUN, lu: pc_write=0, ifid_write=0, idex_bubble=1. Stay in RUN; the bubble clears lu next cycle.
- RUN, none of the above: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0.
- FLUSH: ifid_flush=1, idex_bubble=1, pc_write=1, ifid_write=1. cnt decrements each cycle; return to RUN after the cycle in which cnt==1. lu and ext_stall are ignored in FLUSH. A new ex_branch_taken reloads cnt=BRANCH_PENALTY-1.
- WAIT: pc_write=0, ifid_write=0, idex_bubble=1. wcnt increments each cycle, saturating at 255. Leave for RUN in the first cycle ext_stall=0; that cycle uses the RUN decode. If wcnt reaches WAIT_LIMIT while still stalled, set stall_timeout; it stays set until reset.
- ex_branch_taken in WAIT: handled as in RUN, so flush beats stall.
- stall_cycles: +1 on every clock edge where pc_write=0 and rst_n=1; saturates at 0xFFFF.

## Timing
- Reset (rst_n=0, asynchronous): state=RUN, cnt=0, wcnt=0, stall_cycles=0, stall_timeout=0. While rst_n=0, outputs are forced to pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1.
- Reset mid-FLUSH or mid-WAIT: the state is abandoned immediately. The first cycle after release decodes as RUN.
- Hazard-to-control latency is 0 cycles (combinational). State and counters update on the rising clk edge.
- A load-use stall lasts exactly 1 cycle per dependent pair.
- A taken branch costs BRANCH_PENALTY flushed cycles, including the detection cycle.
- $zero is never a hazard source.

## Structure
- Shared pipeline package holds the state encoding (RUN=2'd0, FLUSH=2'd1, WAIT=2'd2), the register-index width (5), and the stall counter width (16).
- One sub-module is natural: hazard_detect, the combinational lu comparator, reused later by the forwarding unit.
- The FSM, cnt, wcnt and stall_cycles live in the top block.

## Test plan
- Load-use: lw $5 in EX (ex_mem_read=1, ex_rt=5) with id_rs=5 → one cycle of pc_write=0, ifid_write=0, idex_bubble=1, then normal flow; stall_cycles=1. Same with ex_rt=0 → no stall.
- Taken branch, BRANCH_PENALTY=2: ex_branch_taken pulse → ifid_flush=1 and idex_bubble=1 for exactly 2 cycles, with pc_write=1 throughout; a lu asserted in the 2nd cycle is ignored.
- Simultaneous ex_branch_taken, ext_stall and lu → the flush is taken, then ext_stall still high → WAIT.
- ext_stall high for 3 cycles → pc_write=0 for 3 cycles, resumes in the cycle ext_stall drops; stall_cycles=3. Hold it for WAIT_LIMIT=4 cycles → stall_timeout=1, sticky after release.
- rst_n pulsed low in mid-FLUSH → outputs forced to reset values immediately; after release, state RUN and counters 0.
- Drive 70000 stall cycles → stall_cycles saturates at 0xFFFF.

Source files
------------

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared pipeline types for the hazard/stall controller.
// State encoding, register-index width and stall counter width.
package hazard_stall_ctrl_pkg;

    localparam int REG_W   = 5;
    localparam int STALL_W = 16;

    typedef logic [REG_W-1:0] reg_idx_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        WAIT  = 2'd2
    } state_t;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_bubble;
    } ctl_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-side bundle between the ID/EX datapath and the stall controller.
// master = pipeline datapath, slave = controller.
interface hazard_stall_ctrl_if;
    import hazard_stall_ctrl_pkg::*;

    reg_idx_t             id_rs;
    reg_idx_t             id_rt;
    logic                 id_uses_rt;
    logic                 ex_mem_read;
    reg_idx_t             ex_rt;
    logic                 ex_branch_taken;
    logic                 ext_stall;
    logic                 pc_write;
    logic                 ifid_write;
    logic                 ifid_flush;
    logic                 idex_bubble;
    logic [STALL_W-1:0]   stall_cycles;
    logic                 stall_timeout;

    modport master (
        output id_rs, id_rt, id_uses_rt,
        output ex_mem_read, ex_rt,
        output ex_branch_taken, ext_stall,
        input  pc_write, ifid_write,
        input  ifid_flush, idex_bubble,
        input  stall_cycles, stall_timeout
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt,
        input  ex_mem_read, ex_rt,
        input  ex_branch_taken, ext_stall,
        output pc_write, ifid_write,
        output ifid_flush, idex_bubble,
        output stall_cycles, stall_timeout
    );

endinterface

// File: rtl/hazard_stall_ctrl_hazard_detect.sv
// Load-use comparator: a load in EX feeding a source of the ID instruction.
// Purely combinational so the forwarding unit can reuse it.
module hazard_detect
    import hazard_stall_ctrl_pkg::*;
(
    input  reg_idx_t id_rs,
    input  reg_idx_t id_rt,
    input  logic     id_uses_rt,
    input  logic     ex_mem_read,
    input  reg_idx_t ex_rt,
    output logic     lu
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit = (ex_rt == id_rs);
    assign rt_hit = id_uses_rt & (ex_rt == id_rt);

    // $zero writes are discarded, so they never create a dependency
    assign lu = ex_mem_read & (ex_rt != '0) & (rs_hit | rt_hit);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// IF/ID and ID/EX sequencing: load-use stalls, branch flushes, memory waits.
// Mealy outputs; stall and timeout bookkeeping for the front end.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int BRANCH_PENALTY = 2,
    parameter int WAIT_LIMIT     = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_stall_ctrl_if.slave bus
);

    localparam int CW = (BRANCH_PENALTY > 1) ? $clog2(BRANCH_PENALTY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(BRANCH_PENALTY - 1);
    localparam logic [7:0]    WLIM     = 8'(WAIT_LIMIT);

    state_t             state;
    state_t             state_n;
    logic [CW-1:0]      cnt;
    logic [CW-1:0]      cnt_n;
    logic [7:0]         wcnt;
    logic [7:0]         wcnt_n;
    logic [STALL_W-1:0] sc;
    logic               tmo;
    logic               tmo_n;
    logic               lu;
    logic               do_flush;
    logic               do_hold;
    logic               sel_br;
    logic               sel_fl;
    logic               sel_st;
    ctl_t               ctl;

    hazard_detect u_hd (
        .id_rs       (bus.id_rs),
        .id_rt       (bus.id_rt),
        .id_uses_rt  (bus.id_uses_rt),
        .ex_mem_read (bus.ex_mem_read),
        .ex_rt       (bus.ex_rt),
        .lu          (lu)
    );

    assign do_flush = bus.ex_branch_taken | (state == FLUSH);
    assign do_hold  = ~do_flush & (bus.ext_stall | lu);

    assign sel_br = bus.ex_branch_taken;
    assign sel_fl = ~bus.ex_branch_taken & (state == FLUSH);
    assign sel_st = ~bus.ex_branch_taken & (state != FLUSH)
                  & bus.ext_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= '0;
            wcnt  <= '0;
            sc    <= '0;
            tmo   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            wcnt  <= wcnt_n;
            tmo   <= tmo_n;
            if (!ctl.pc_write && sc != '1)
                sc <= sc + STALL_W'(1);
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        wcnt_n  = wcnt;
        tmo_n   = tmo;
        unique case (1'b1)
            sel_br: begin
                state_n = (BRANCH_PENALTY > 1) ? FLUSH : RUN;
                cnt_n   = CNT_LOAD;
                wcnt_n  = '0;
            end
            sel_fl: begin
                cnt_n = cnt - CW'(1);
                if (cnt == CW'(1))
                    state_n = RUN;
            end
            sel_st: begin
                state_n = WAIT;
                wcnt_n  = (state == WAIT) ? sat_inc8(wcnt) : 8'd1;
                if (wcnt_n >= WLIM)
                    tmo_n = 1'b1;
            end
            default: begin
                state_n = RUN;
                wcnt_n  = '0;
            end
        endcase
    end

    // reset holds the front end frozen and ID/EX bubbled
    always_comb begin
        ctl = 4'b1100;
        if (!rst_n) begin
            ctl = 4'b0011;
        end else begin
            unique case (1'b1)
                do_flush: ctl = 4'b1111;
                do_hold:  ctl = 4'b0001;
                default:  ctl = 4'b1100;
            endcase
        end
    end

    assign bus.pc_write      = ctl.pc_write;
    assign bus.ifid_write    = ctl.ifid_write;
    assign bus.ifid_flush    = ctl.ifid_flush;
    assign bus.idex_bubble   = ctl.idex_bubble;
    assign bus.stall_cycles  = sc;
    assign bus.stall_timeout = tmo;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl with BRANCH_PENALTY=2, WAIT_LIMIT=4.
// ctl below is {pc_write, ifid_write, ifid_flush, idex_bubble}.
module tb_hazard_stall_ctrl;
    import hazard_stall_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   ncmp = 0;
    int   nerr = 0;

    hazard_stall_ctrl_if bus();

    wire [3:0] ctl = {bus.pc_write, bus.ifid_write,
                      bus.ifid_flush, bus.idex_bubble};

    always #5 clk = ~clk;

    hazard_stall_ctrl #(
        .BRANCH_PENALTY (2),
        .WAIT_LIMIT     (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic set_idle;
        bus.id_rs = '0; bus.id_rt = '0; bus.id_uses_rt = 1'b0;
        bus.ex_mem_read = 1'b0; bus.ex_rt = '0;
        bus.ex_branch_taken = 1'b0; bus.ext_stall = 1'b0;
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                         input logic ut, input logic mr,
                         input logic [4:0] ert, input logic bt,
                         input logic es);
        @(negedge clk);
        bus.id_rs = rs; bus.id_rt = rt; bus.id_uses_rt = ut;
        bus.ex_mem_read = mr; bus.ex_rt = ert;
        bus.ex_branch_taken = bt; bus.ext_stall = es;
        #1;
    endtask

    task automatic apply_reset;
        @(negedge clk);
        rst_n = 1'b0;
        set_idle();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        set_idle();
        #1;
        ncmp++; if (ctl !== 4'b0011) begin nerr++;
            $display("FAIL reset_ctl: got %b want 0011", ctl); end
        ncmp++; if (bus.stall_cycles !== 16'd0) begin nerr++;
            $display("FAIL reset_sc: got %0d want 0", bus.stall_cycles); end
        ncmp++; if (bus.stall_timeout !== 1'b0) begin nerr++;
            $display("FAIL reset_tmo: got %b want 0", bus.stall_timeout); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        ncmp++; if (ctl !== 4'b1100) begin nerr++;
            $display("FAIL reset_release: got %b want 1100", ctl); end
    endtask

    task automatic test_load_use;
        apply_reset();
        drive(5, 0, 0, 1, 5, 0, 0);
        ncmp++; if (ctl !== 4'b0001) begin nerr++;
            $display("FAIL lu_rs: got %b want 0001", ctl); end
        drive(5, 0, 0, 0, 0, 0, 0);
        ncmp++; if (ctl !== 4'b1100) begin nerr++;
            $display("FAIL lu_resume: got %b want 1100", ctl); end
        ncmp++; if (bus.stall_cycles !== 16'd1) begin nerr++;
            $display("FAIL lu_count: got %0d want 1", bus.stall_cycles); end
        drive(0, 0, 0, 1, 0, 0, 0);
        ncmp++; if (ctl !== 4'b1100) begin nerr++;
            $display("FAIL lu_zero: got %b want 1100", ctl); end
        drive(3, 7, 1, 1, 7, 0, 0);
        ncmp++; if (ctl !== 4'b0001) begin nerr++;
            $display("FAIL lu_rt: got %b want 0001", ctl); end
        drive(3, 7, 0, 1, 7, 0, 0);
        ncmp++; if (ctl !== 4'b1100) begin nerr++;
            $display("FAIL lu_rt_unused: got %b want 1100", ctl); end
        ncmp++; if (bus.stall_cycles !== 16'd2) begin nerr++;
            $display("FAIL lu_count2: got %0d want 2", bus.stall_cycles); end
    endtask

    task automatic test_branch;
        apply_reset();
        drive(0, 0, 0, 0, 0, 1, 0);
        ncmp++; if (ctl !== 4'b1111) begin nerr++;
            $display("FAIL br_c1: got %b want 1111", ctl); end
        drive(5, 0, 0, 1, 5, 0, 0);
        ncmp++; if (ctl !== 4'b1111) begin nerr++;
            $display("FAIL br_c2_lu_ignored: got %b want 1111", ctl); end
        drive(0, 0, 0, 0, 0, 0, 0);
        ncmp++; if (ctl !== 4'b1100) begin nerr++;
            $display("FAIL br_done: got %b want 1100", ctl); end
        ncmp++; if (bus.stall_cycles !== 16'd0) begin nerr++;
            $display("FAIL br_count: got %0d want 0", bus.stall_cycles); end
    endtask

    task automatic test_simultaneous;
        apply_reset();
        drive(5, 0, 0, 1, 5, 1, 1);
        ncmp++; if (ctl !== 4'b1111) begin nerr++;
            $display("FAIL sim_flush: got %b want 1111", ctl); end
        drive(0, 0, 0, 0, 0, 0, 1);
        ncmp++; if (ctl !== 4'b1111) begin nerr++;
            $display("FAIL sim_flush2: got %b want 1111", ctl); end
        drive(0, 0, 0, 0, 0, 0, 1);
        ncmp++; if (ctl !== 4'b0001) begin nerr++;
            $display("FAIL sim_stall: got %b want 0001", ctl); end
        drive(0, 0, 0, 0, 0, 0, 1);
        ncmp++; if (ctl !== 4'b0001) begin nerr++;
            $display("FAIL sim_wait: got %b want 0001", ctl); end
        drive(0, 0, 0, 0, 0, 0, 0);
        ncmp++; if (ctl !== 4'b1100) begin nerr++;
            $display("FAIL sim_resume: got %b want 1100", ctl); end
        ncmp++; if (bus.stall_cycles !== 16'd2) begin nerr++;
            $display("FAIL sim_count: got %0d want 2", bus.stall_cycles); end
    endtask

    task automatic test_ext_stall;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0, 1);
            ncmp++; if (ctl !== 4'b0001) begin nerr++;
                $display("FAIL es_hold%0d: got %b want 0001", i, ctl); end
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        ncmp++; if (ctl !== 4'b1100) begin nerr++;
            $display("FAIL es_resume: got %b want 1100", ctl); end
        ncmp++; if (bus.stall_cycles !== 16'd3) begin nerr++;
            $display("FAIL es_count: got %0d want 3", bus.stall_cycles); end
        ncmp++; if (bus.stall_timeout !== 1'b0) begin nerr++;
            $display("FAIL es_tmo_short: got %b want 0", bus.stall_timeout); end
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 0, 0, 1);
            if (i == 3) begin
                ncmp++; if (bus.stall_timeout !== 1'b0) begin nerr++;
                    $display("FAIL es_tmo_pre: got %b want 0", bus.stall_timeout); end
            end
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        ncmp++; if (bus.stall_timeout !== 1'b1) begin nerr++;
            $display("FAIL es_tmo_set: got %b want 1", bus.stall_timeout); end
        ncmp++; if (ctl !== 4'b1100) begin nerr++;
            $display("FAIL es_tmo_resume: got %b want 1100", ctl); end
        drive(0, 0, 0, 0, 0, 0, 0);
        ncmp++; if (bus.stall_timeout !== 1'b1) begin nerr++;
            $display("FAIL es_tmo_sticky: got %b want 1", bus.stall_timeout); end
    endtask

    task automatic test_branch_in_wait;
        apply_reset();
        drive(0, 0, 0, 0, 0, 0, 1);
        ncmp++; if (ctl !== 4'b0001) begin nerr++;
            $display("FAIL biw_enter: got %b want 0001", ctl); end
        drive(0, 0, 0, 0, 0, 1, 1);
        ncmp++; if (ctl !== 4'b1111) begin nerr++;
            $display("FAIL biw_flush: got %b want 1111", ctl); end
        drive(0, 0, 0, 0, 0, 0, 1);
        ncmp++; if (ctl !== 4'b1111) begin nerr++;
            $display("FAIL biw_flush2: got %b want 1111", ctl); end
        drive(0, 0, 0, 0, 0, 0, 1);
        ncmp++; if (ctl !== 4'b0001) begin nerr++;
            $display("FAIL biw_stall: got %b want 0001", ctl); end
        drive(5, 0, 0, 1, 5, 0, 0);
        ncmp++; if (ctl !== 4'b0001) begin nerr++;
            $display("FAIL biw_exit_lu: got %b want 0001", ctl); end
        drive(0, 0, 0, 0, 0, 0, 0);
        ncmp++; if (ctl !== 4'b1100) begin nerr++;
            $display("FAIL biw_done: got %b want 1100", ctl); end
    endtask

    task automatic test_reset_mid_flush;
        apply_reset();
        drive(5, 0, 0, 1, 5, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 0);
        ncmp++; if (ctl !== 4'b1111) begin nerr++;
            $display("FAIL rmf_br: got %b want 1111", ctl); end
        drive(0, 0, 0, 0, 0, 1, 0);
        ncmp++; if (ctl !== 4'b1111) begin nerr++;
            $display("FAIL rmf_reload: got %b want 1111", ctl); end
        #2;
        bus.ex_branch_taken = 1'b0;
        rst_n = 1'b0;
        #1;
        ncmp++; if (ctl !== 4'b0011) begin nerr++;
            $display("FAIL rmf_forced: got %b want 0011", ctl); end
        ncmp++; if (bus.stall_cycles !== 16'd0) begin nerr++;
            $display("FAIL rmf_sc: got %0d want 0", bus.stall_cycles); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        ncmp++; if (ctl !== 4'b1100) begin nerr++;
            $display("FAIL rmf_run: got %b want 1100", ctl); end
    endtask

    task automatic test_saturation;
        apply_reset();
        @(negedge clk);
        bus.ext_stall = 1'b1;
        repeat (70000) @(posedge clk);
        @(negedge clk);
        ncmp++; if (bus.stall_cycles !== 16'hFFFF) begin nerr++;
            $display("FAIL sat_sc: got %h want ffff", bus.stall_cycles); end
        ncmp++; if (bus.stall_timeout !== 1'b1) begin nerr++;
            $display("FAIL sat_tmo: got %b want 1", bus.stall_timeout); end
        bus.ext_stall = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_simultaneous();
        test_ext_stall();
        test_branch_in_wait();
        test_reset_mid_flush();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
